// File: rtl/sata_prim_decode.sv
// SATA receive primitive decoder: classifies each aligned receive dword as a primitive or payload,
// tracks framing and CONT repetition, and reports protocol errors with a saturating counter.
//
// state    | meaning
// ST_IDLE  | no frame open; payload dwords are protocol errors
// ST_FRAME | SOF accepted, no EOF/SYNC yet; payload dwords are forwarded
module sata_prim_decode (
    input  logic        clk_75m,
    input  logic        host_rst,
    input  logic        link_up,
    input  logic [31:0] phy2cs_data,
    input  logic        phy2cs_k,
    output logic        prim_valid,
    output logic [4:0]  prim_code,
    output logic [31:0] rx_data,
    output logic        rx_data_valid,
    output logic        in_frame,
    output logic        cont_active,
    output logic        frame_abort,
    output logic        prot_err,
    output logic [15:0] err_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } frame_state_t;

    localparam logic [31:0] P_SYNC    = 32'hB5B5_957C;
    localparam logic [31:0] P_R_RDY   = 32'h4A4A_957C;
    localparam logic [31:0] P_X_RDY   = 32'h5757_B57C;
    localparam logic [31:0] P_SOF     = 32'h3737_B57C;
    localparam logic [31:0] P_EOF     = 32'hD5D5_B57C;
    localparam logic [31:0] P_HOLD    = 32'hD5D5_AA7C;
    localparam logic [31:0] P_HOLDA   = 32'h9595_AA7C;
    localparam logic [31:0] P_R_IP    = 32'h5555_B57C;
    localparam logic [31:0] P_R_OK    = 32'h3535_B57C;
    localparam logic [31:0] P_R_ERR   = 32'h5656_B57C;
    localparam logic [31:0] P_WTRM    = 32'h5858_B57C;
    localparam logic [31:0] P_DMAT    = 32'h3636_B57C;
    localparam logic [31:0] P_PMREQ_P = 32'h1717_B57C;
    localparam logic [31:0] P_PMREQ_S = 32'h7575_957C;
    localparam logic [31:0] P_PMACK   = 32'h9595_957C;
    localparam logic [31:0] P_PMNAK   = 32'hF5F5_957C;
    localparam logic [31:0] P_ALIGN   = 32'h7B4A_4ABC;
    localparam logic [31:0] P_CONT    = 32'h9999_AA7C;

    localparam logic [4:0] PC_SYNC    = 5'd0;
    localparam logic [4:0] PC_SOF     = 5'd3;
    localparam logic [4:0] PC_EOF     = 5'd4;
    localparam logic [4:0] PC_UNKNOWN = 5'd31;

    frame_state_t state_q, state_d;
    logic         cont_q, cont_d;
    logic [4:0]   last_q, last_d;

    logic         pv_d, rdv_d, fa_d, pe_d;
    logic [4:0]   code_d;
    logic [31:0]  rdata_d;
    logic [15:0]  err_d;

    logic [4:0]   dec_code;
    logic         dec_align;
    logic         dec_cont;

    always_comb begin
        dec_code  = PC_UNKNOWN;
        dec_align = 1'b0;
        dec_cont  = 1'b0;
        case (phy2cs_data)
            P_SYNC:    dec_code = 5'd0;
            P_R_RDY:   dec_code = 5'd1;
            P_X_RDY:   dec_code = 5'd2;
            P_SOF:     dec_code = 5'd3;
            P_EOF:     dec_code = 5'd4;
            P_HOLD:    dec_code = 5'd5;
            P_HOLDA:   dec_code = 5'd6;
            P_R_IP:    dec_code = 5'd7;
            P_R_OK:    dec_code = 5'd8;
            P_R_ERR:   dec_code = 5'd9;
            P_WTRM:    dec_code = 5'd10;
            P_DMAT:    dec_code = 5'd11;
            P_PMREQ_P: dec_code = 5'd12;
            P_PMREQ_S: dec_code = 5'd13;
            P_PMACK:   dec_code = 5'd14;
            P_PMNAK:   dec_code = 5'd15;
            P_ALIGN:   dec_align = 1'b1;
            P_CONT:    dec_cont  = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cont_d  = cont_q;
        last_d  = last_q;
        pv_d    = 1'b0;
        code_d  = prim_code;
        rdv_d   = 1'b0;
        rdata_d = rx_data;
        fa_d    = 1'b0;
        pe_d    = 1'b0;

        if (!link_up) begin
            state_d = ST_IDLE;
            cont_d  = 1'b0;
            last_d  = PC_SYNC;
            code_d  = 5'd0;
            rdata_d = 32'd0;
        end else if (phy2cs_k) begin
            if (dec_align) begin
                // ALIGN is link filler: invisible downstream, no state change
            end else if (dec_cont) begin
                cont_d = 1'b1;
                pv_d   = 1'b1;
                code_d = last_q;
            end else begin
                cont_d = 1'b0;
                pv_d   = 1'b1;
                code_d = dec_code;
                if (dec_code == PC_UNKNOWN) begin
                    pe_d = 1'b1;
                end else begin
                    last_d = dec_code;
                    case (dec_code)
                        PC_SOF: begin
                            pe_d    = (state_q == ST_FRAME);
                            state_d = ST_FRAME;
                        end
                        PC_EOF: begin
                            pe_d    = (state_q == ST_IDLE);
                            state_d = ST_IDLE;
                        end
                        PC_SYNC: begin
                            fa_d    = (state_q == ST_FRAME);
                            state_d = ST_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
        end else if (cont_q) begin
            // scrambled junk between CONT and the next primitive stands for last_prim
            pv_d   = 1'b1;
            code_d = last_q;
        end else if (state_q == ST_FRAME) begin
            rdv_d   = 1'b1;
            rdata_d = phy2cs_data;
        end else begin
            pe_d = 1'b1;
        end
    end

    always_comb begin
        err_d = err_cnt;
        if (pe_d && (err_cnt != 16'hFFFF)) begin
            err_d = err_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_75m or posedge host_rst) begin
        if (host_rst) begin
            state_q       <= ST_IDLE;
            cont_q        <= 1'b0;
            last_q        <= PC_SYNC;
            prim_valid    <= 1'b0;
            prim_code     <= 5'd0;
            rx_data       <= 32'd0;
            rx_data_valid <= 1'b0;
            frame_abort   <= 1'b0;
            prot_err      <= 1'b0;
            err_cnt       <= 16'd0;
        end else begin
            state_q       <= state_d;
            cont_q        <= cont_d;
            last_q        <= last_d;
            prim_valid    <= pv_d;
            prim_code     <= code_d;
            rx_data       <= rdata_d;
            rx_data_valid <= rdv_d;
            frame_abort   <= fa_d;
            prot_err      <= pe_d;
            err_cnt       <= err_d;
        end
    end

    assign in_frame    = (state_q == ST_FRAME);
    assign cont_active = cont_q;

endmodule

// File: tb/tb_sata_prim_decode.sv
// Scoreboard bench for sata_prim_decode: a driver feeds dwords and queues the reference
// model's expected response; a negedge monitor pops and compares the registered outputs.
module tb_sata_prim_decode;

    logic        clk_75m = 1'b0;
    logic        host_rst = 1'b1;
    logic        link_up = 1'b0;
    logic [31:0] phy2cs_data = 32'd0;
    logic        phy2cs_k = 1'b0;
    logic        prim_valid;
    logic [4:0]  prim_code;
    logic [31:0] rx_data;
    logic        rx_data_valid;
    logic        in_frame;
    logic        cont_active;
    logic        frame_abort;
    logic        prot_err;
    logic [15:0] err_cnt;

    sata_prim_decode dut (
        .clk_75m       (clk_75m),
        .host_rst      (host_rst),
        .link_up       (link_up),
        .phy2cs_data   (phy2cs_data),
        .phy2cs_k      (phy2cs_k),
        .prim_valid    (prim_valid),
        .prim_code     (prim_code),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .in_frame      (in_frame),
        .cont_active   (cont_active),
        .frame_abort   (frame_abort),
        .prot_err      (prot_err),
        .err_cnt       (err_cnt)
    );

    always #6 clk_75m = ~clk_75m;

    int cyc = 0;
    always @(posedge clk_75m) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // index = primitive code; 16 = ALIGN, 17 = CONT
    logic [31:0] prim_tab [18] = '{
        32'hB5B5957C, 32'h4A4A957C, 32'h5757B57C, 32'h3737B57C,
        32'hD5D5B57C, 32'hD5D5AA7C, 32'h9595AA7C, 32'h5555B57C,
        32'h3535B57C, 32'h5656B57C, 32'h5858B57C, 32'h3636B57C,
        32'h1717B57C, 32'h7575957C, 32'h9595957C, 32'hF5F5957C,
        32'h7B4A4ABC, 32'h9999AA7C };

    typedef struct {
        logic        pv;
        logic [4:0]  code;
        logic        rdv;
        logic [31:0] rdata;
        logic        inf;
        logic        cont;
        logic        fa;
        logic        pe;
        logic [15:0] errc;
        int          due;
    } exp_t;

    exp_t sb[$];

    // reference state
    bit m_in   = 1'b0;
    bit m_cont = 1'b0;
    int m_last = 0;
    int m_err  = 0;

    function automatic int lookup(input logic [31:0] d);
        for (int i = 0; i < 18; i++) if (prim_tab[i] == d) return i;
        return 31;
    endfunction

    task automatic drive(input bit lu, input bit k, input logic [31:0] d);
        exp_t e;
        int   p;
        @(posedge clk_75m);
        #1;
        link_up = lu; phy2cs_k = k; phy2cs_data = d;
        e.pv = 0; e.code = 0; e.rdv = 0; e.rdata = 0; e.fa = 0; e.pe = 0;
        if (!lu) begin
            m_in = 0; m_cont = 0; m_last = 0;
        end else if (k) begin
            p = lookup(d);
            if (p == 17) begin
                m_cont = 1; e.pv = 1; e.code = 5'(m_last);
            end else if (p != 16) begin
                m_cont = 0; e.pv = 1; e.code = 5'(p);
                if (p == 31) e.pe = 1;
                else begin
                    m_last = p;
                    if (p == 3) begin e.pe = m_in; m_in = 1; end
                    if (p == 4) begin e.pe = !m_in; m_in = 0; end
                    if (p == 0) begin e.fa = m_in; m_in = 0; end
                end
            end
        end else if (m_cont) begin
            e.pv = 1; e.code = 5'(m_last);
        end else if (m_in) begin
            e.rdv = 1; e.rdata = d;
        end else begin
            e.pe = 1;
        end
        if (e.pe && m_err < 65535) m_err++;
        e.inf = m_in; e.cont = m_cont; e.errc = 16'(m_err); e.due = cyc + 1;
        sb.push_back(e);
    endtask

    // ALIGN is a no-op, so holding it on the bus while waiting adds no unchecked activity
    task automatic drain();
        drive(1, 1, prim_tab[16]);
        for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk_75m);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    always @(negedge clk_75m) begin : monitor
        exp_t e;
        bit   bad;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            tests++; fails++;
            $display("FAIL sb_stale due=%0d now=%0d", e.due, cyc);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            tests++;
            bad = (prim_valid !== e.pv) || (e.pv && prim_code !== e.code) ||
                  (rx_data_valid !== e.rdv) || (e.rdv && rx_data !== e.rdata) ||
                  (in_frame !== e.inf) || (cont_active !== e.cont) ||
                  (frame_abort !== e.fa) || (prot_err !== e.pe) || (err_cnt !== e.errc) ||
                  (prim_valid && rx_data_valid) || (prot_err && frame_abort);
            if (bad) begin
                fails++;
                $display("FAIL sb_cycle cyc=%0d got pv=%b code=%0d rdv=%b rd=%h inf=%b cont=%b fa=%b pe=%b err=%h required pv=%b code=%0d rdv=%b rd=%h inf=%b cont=%b fa=%b pe=%b err=%h",
                         cyc, prim_valid, prim_code, rx_data_valid, rx_data, in_frame, cont_active,
                         frame_abort, prot_err, err_cnt, e.pv, e.code, e.rdv, e.rdata, e.inf,
                         e.cont, e.fa, e.pe, e.errc);
            end
        end
    end

    initial begin
        int r;
        int pick;
        repeat (3) @(negedge clk_75m);
        chk("rst_prim_valid", 32'(prim_valid), 0);
        chk("rst_in_frame", 32'(in_frame), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        host_rst = 1'b0;

        // SOF / two data / EOF
        drive(1, 1, prim_tab[3]);
        drive(1, 0, 32'h11223344);
        drive(1, 0, 32'h55667788);
        drive(1, 1, prim_tab[4]);
        // HOLD, CONT, junk x3, ALIGN, R_IP
        drive(1, 1, prim_tab[5]);
        drive(1, 1, prim_tab[17]);
        drive(1, 0, 32'hDEADBEEF);
        drive(1, 0, 32'h0BADF00D);
        drive(1, 0, 32'h12345678);
        drive(1, 1, prim_tab[16]);
        drive(1, 1, prim_tab[7]);
        // abort by SYNC
        drive(1, 1, prim_tab[3]);
        drive(1, 0, 32'hA5A5A5A5);
        drive(1, 1, prim_tab[0]);
        // three protocol errors
        drive(1, 0, 32'h00000001);
        drive(1, 1, 32'h12345678);
        drive(1, 1, prim_tab[4]);
        drain();
        chk("err_cnt_three", 32'(err_cnt), 3);

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            pick = int'($urandom_range(0, 17));
            if (r < 2)       drive(0, 1'($urandom_range(0, 1)), $urandom);
            else if (r < 45) drive(1, 0, $urandom);
            else if (r < 50) drive(1, 1, $urandom);
            else             drive(1, 1, prim_tab[pick]);
        end
        drain();

        // saturate the error counter, then drop link mid-CONT inside a frame
        drive(1, 1, prim_tab[0]);
        for (int i = 0; i < 65540; i++) drive(1, 0, 32'(i));
        drive(1, 1, prim_tab[3]);
        drive(1, 1, prim_tab[5]);
        drive(1, 1, prim_tab[17]);
        drive(1, 0, 32'hCAFEF00D);
        drive(0, 1, prim_tab[17]);
        drive(1, 0, 32'h0000BEEF);
        drain();
        chk("err_cnt_sat", 32'(err_cnt), 32'hFFFF);
        chk("cont_after_linkdown", 32'(cont_active), 0);

        // asynchronous reset mid-frame
        drive(1, 1, prim_tab[3]);
        drive(1, 0, 32'h87654321);
        drain();
        chk("pre_rst_in_frame", 32'(in_frame), 1);
        link_up = 1'b0;
        @(negedge clk_75m);
        #3 host_rst = 1'b1;
        #1;
        chk("arst_prim_valid", 32'(prim_valid), 0);
        chk("arst_prim_code", 32'(prim_code), 0);
        chk("arst_rx_data", rx_data, 0);
        chk("arst_rx_data_valid", 32'(rx_data_valid), 0);
        chk("arst_in_frame", 32'(in_frame), 0);
        chk("arst_cont_active", 32'(cont_active), 0);
        chk("arst_frame_abort", 32'(frame_abort), 0);
        chk("arst_prot_err", 32'(prot_err), 0);
        chk("arst_err_cnt", 32'(err_cnt), 0);
        m_in = 0; m_cont = 0; m_last = 0; m_err = 0;
        @(negedge clk_75m);
        host_rst = 1'b0;
        @(posedge clk_75m);
        #1;
        chk("post_rst_linkdown_pv", 32'(prim_valid), 0);
        drive(1, 0, 32'h13579BDF);
        drive(1, 1, prim_tab[17]);
        drive(1, 0, 32'h2468ACE0);
        drive(1, 1, prim_tab[3]);
        drive(1, 0, 32'h2468ACE0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
